// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch levels and hold in, debounced byte and strobes out; SW_EDGE_EN adds rise/fall strobes
interface switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic             hold;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_changed;
    logic             change_any;
`ifdef SW_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    modport master (
        output sw_raw, hold,
        input  sw_stable, sw_changed, change_any, sw_rise, sw_fall
    );
    modport slave (
        input  sw_raw, hold,
        output sw_stable, sw_changed, change_any, sw_rise, sw_fall
    );
`else
    modport master (
        output sw_raw, hold,
        input  sw_stable, sw_changed, change_any
    );
    modport slave (
        input  sw_raw, hold,
        output sw_stable, sw_changed, change_any
    );
`endif
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit synchronizer + debounce counter with hold freeze and change strobes; SW_EDGE_EN adds rise/fall strobes
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic clk,
    input logic clr,
    switch_debouncer_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic {IDLE, PENDING} state_t;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] mism;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] changed_q, commit_d;
    logic             change_any_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    assign s    = sync_q[SYNC_STAGES-1];
    assign mism = s ^ stable_q;
    // synchronizer chain bringing the asynchronous switch levels into the clk domain
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.sw_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end
    // per-bit IDLE/PENDING next state: count mismatches, saturate under hold, commit when the count is full
    always_comb begin
        commit_d = '0;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
            if (mism[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i]   = (state_q[i] == IDLE) ? CW'(1) : cnt_q[i] + CW'(1);
                    state_d[i] = PENDING;
                end else if (bus.hold) begin
                    cnt_d[i]   = CNT_MAX;
                    state_d[i] = PENDING;
                end else begin
                    commit_d[i] = 1'b1;
                    stable_d[i] = s[i];
                end
            end
        end
    end
    // state, counter, debounced value and change strobes
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
            stable_q     <= '0;
            changed_q    <= '0;
            change_any_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
            stable_q     <= stable_d;
            changed_q    <= commit_d;
            change_any_q <= |commit_d;
        end
    end
    assign bus.sw_stable  = stable_q;
    assign bus.sw_changed = changed_q;
    assign bus.change_any = change_any_q;
`ifdef SW_EDGE_EN
    logic [WIDTH-1:0] rise_q, fall_q;
    // direction-qualified strobes registered alongside sw_changed
    always_ff @(posedge clk) begin
        if (clr) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= commit_d & stable_d;
            fall_q <= commit_d & ~stable_d;
        end
    end
    assign bus.sw_rise = rise_q;
    assign bus.sw_fall = fall_q;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed tests of switch_debouncer with default parameters
module tb_switch_debouncer;
    logic clk = 1'b0;
    logic clr;
    int total = 0;
    int bad = 0;
    switch_debouncer_if #(.WIDTH(8)) bus_if ();
    switch_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus_if)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic go_to(input logic [7:0] v);
        bus_if.sw_raw = v;
        repeat (22) step();
    endtask
    task automatic test_reset();
        bus_if.sw_raw = 8'hFF;
        bus_if.hold = 1'b0;
        clr = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            total++;
            if ({bus_if.sw_stable, bus_if.sw_changed, 7'd0, bus_if.change_any} !== 24'h0) begin
                bad++;
                $display("FAIL reset_outputs: got %h/%h/%b want 00/00/0", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
            end
`ifdef SW_EDGE_EN
            total++;
            if ({bus_if.sw_rise, bus_if.sw_fall} !== 16'h0) begin
                bad++;
                $display("FAIL reset_edges: got %h/%h want 00/00", bus_if.sw_rise, bus_if.sw_fall);
            end
`endif
        end
        clr = 1'b0;
        for (int n = 0; n < 17; n++) begin
            step();
            total++;
            if (bus_if.sw_stable !== 8'h00 || bus_if.change_any !== 1'b0) begin
                bad++;
                $display("FAIL reset_early edge %0d: got %h/%b want 00/0", n, bus_if.sw_stable, bus_if.change_any);
            end
        end
        step();
        total++;
        if (bus_if.sw_stable !== 8'hFF || bus_if.sw_changed !== 8'hFF || bus_if.change_any !== 1'b1) begin
            bad++;
            $display("FAIL reset_commit: got %h/%h/%b want FF/FF/1", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
        step();
        total++;
        if (bus_if.sw_stable !== 8'hFF || bus_if.sw_changed !== 8'h00 || bus_if.change_any !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulse_end: got %h/%h/%b want FF/00/0", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
    endtask
    task automatic test_clean_change();
        go_to(8'h00);
        bus_if.sw_raw = 8'h08;
        for (int n = 0; n < 17; n++) begin
            step();
            total++;
            if (bus_if.sw_stable !== 8'h00 || bus_if.sw_changed !== 8'h00) begin
                bad++;
                $display("FAIL clean_early edge %0d: got %h/%h want 00/00", n, bus_if.sw_stable, bus_if.sw_changed);
            end
        end
        step();
        total++;
        if (bus_if.sw_stable !== 8'h08 || bus_if.sw_changed !== 8'h08 || bus_if.change_any !== 1'b1) begin
            bad++;
            $display("FAIL clean_commit: got %h/%h/%b want 08/08/1", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
`ifdef SW_EDGE_EN
        total++;
        if (bus_if.sw_rise !== 8'h08 || bus_if.sw_fall !== 8'h00) begin
            bad++;
            $display("FAIL clean_edges: got %h/%h want 08/00", bus_if.sw_rise, bus_if.sw_fall);
        end
`endif
        step();
        total++;
        if (bus_if.sw_changed !== 8'h00 || bus_if.change_any !== 1'b0) begin
            bad++;
            $display("FAIL clean_pulse_end: got %h/%b want 00/0", bus_if.sw_changed, bus_if.change_any);
        end
    endtask
    task automatic test_glitch();
        go_to(8'h00);
        bus_if.sw_raw = 8'h01;
        for (int n = 0; n < 60; n++) begin
            if (n >= 10 && n < 40 && (n - 10) % 3 == 0) bus_if.sw_raw[0] = ~bus_if.sw_raw[0];
            if (n == 40) bus_if.sw_raw = 8'h00;
            step();
            total++;
            if (bus_if.sw_stable !== 8'h00 || bus_if.sw_changed !== 8'h00 || bus_if.change_any !== 1'b0) begin
                bad++;
                $display("FAIL glitch cycle %0d: got %h/%h/%b want 00/00/0", n, bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
            end
        end
    endtask
    task automatic test_hold();
        go_to(8'h00);
        bus_if.hold = 1'b1;
        bus_if.sw_raw = 8'h80;
        for (int n = 0; n < 40; n++) begin
            step();
            total++;
            if (bus_if.sw_stable !== 8'h00 || bus_if.sw_changed !== 8'h00) begin
                bad++;
                $display("FAIL hold_frozen cycle %0d: got %h/%h want 00/00", n, bus_if.sw_stable, bus_if.sw_changed);
            end
        end
        bus_if.hold = 1'b0;
        step();
        total++;
        if (bus_if.sw_stable !== 8'h80 || bus_if.sw_changed !== 8'h80 || bus_if.change_any !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got %h/%h/%b want 80/80/1", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
        step();
        total++;
        if (bus_if.sw_changed !== 8'h00) begin
            bad++;
            $display("FAIL hold_pulse_end: got %h want 00", bus_if.sw_changed);
        end
    endtask
    task automatic test_reset_mid_count();
        go_to(8'h00);
        bus_if.sw_raw = 8'h03;
        repeat (10) step();
        clr = 1'b1;
        step();
        total++;
        if (bus_if.sw_stable !== 8'h00 || bus_if.sw_changed !== 8'h00 || bus_if.change_any !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h/%h/%b want 00/00/0", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
        clr = 1'b0;
        for (int n = 0; n < 17; n++) begin
            step();
            total++;
            if (bus_if.sw_stable !== 8'h00 || bus_if.sw_changed !== 8'h00) begin
                bad++;
                $display("FAIL midreset_early edge %0d: got %h/%h want 00/00", n, bus_if.sw_stable, bus_if.sw_changed);
            end
        end
        step();
        total++;
        if (bus_if.sw_stable !== 8'h03 || bus_if.sw_changed !== 8'h03) begin
            bad++;
            $display("FAIL midreset_commit: got %h/%h want 03/03", bus_if.sw_stable, bus_if.sw_changed);
        end
    endtask
    task automatic test_simultaneous();
        go_to(8'hF0);
        total++;
        if (bus_if.sw_stable !== 8'hF0) begin
            bad++;
            $display("FAIL simul_setup: got %h want F0", bus_if.sw_stable);
        end
        bus_if.sw_raw = 8'h0F;
        for (int n = 0; n < 17; n++) begin
            step();
            total++;
            if (bus_if.sw_stable !== 8'hF0 || bus_if.sw_changed !== 8'h00) begin
                bad++;
                $display("FAIL simul_early edge %0d: got %h/%h want F0/00", n, bus_if.sw_stable, bus_if.sw_changed);
            end
        end
        step();
        total++;
        if (bus_if.sw_stable !== 8'h0F || bus_if.sw_changed !== 8'hFF || bus_if.change_any !== 1'b1) begin
            bad++;
            $display("FAIL simul_commit: got %h/%h/%b want 0F/FF/1", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
`ifdef SW_EDGE_EN
        total++;
        if (bus_if.sw_rise !== 8'h0F || bus_if.sw_fall !== 8'hF0) begin
            bad++;
            $display("FAIL simul_edges: got %h/%h want 0F/F0", bus_if.sw_rise, bus_if.sw_fall);
        end
`endif
        step();
        total++;
        if (bus_if.sw_stable !== 8'h0F || bus_if.sw_changed !== 8'h00 || bus_if.change_any !== 1'b0) begin
            bad++;
            $display("FAIL simul_pulse_end: got %h/%h/%b want 0F/00/0", bus_if.sw_stable, bus_if.sw_changed, bus_if.change_any);
        end
    endtask
    initial begin
        clr = 1'b1;
        bus_if.sw_raw = 8'h00;
        bus_if.hold = 1'b0;
        test_reset();
        test_clean_change();
        test_glitch();
        test_hold();
        test_reset_mid_count();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
